// File: rtl/audio_pkg.sv
// Shared audio definitions: mixer FSM encoding, sample midpoint and accumulator
// sizing, plus the sample period common to the players and the mixer.
package audio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SUM   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WRITE = 2'd3
   } mix_state_t;

   localparam int DEFAULT_TICK_PERIOD = 2085;

   function automatic int sample_mid(input int sample_w);
      return 1 << (sample_w - 1);
   endfunction

   // One extra bit per doubling of voices keeps the worst-case sum in range.
   function automatic int acc_w(input int sample_w, input int num_voices);
      return sample_w + $clog2(num_voices);
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-rate tick: tick_cnt runs 0..TICK_PERIOD-1 and tick marks the last count.
// Shared with the sample players so producer and mixer stay phase-locked.
module sample_tick_gen
   import audio_pkg::*;
#(
   parameter int TICK_PERIOD = DEFAULT_TICK_PERIOD,
   localparam int CNT_W = $clog2(TICK_PERIOD)
) (
   input  logic CLOCK_50,
   input  logic reset,
   output logic tick
);

   logic [CNT_W-1:0] tick_cnt;

   assign tick = (tick_cnt == CNT_W'(TICK_PERIOD - 1));

   always_ff @(posedge CLOCK_50) begin
      if (reset)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

endmodule

// File: rtl/voice_mixer.sv
// Mixes NUM_VOICES offset-binary voices into one signed PCM word per sample tick
// and writes it to both codec channels. Optional macro: VOICE_MIXER_OVERRUN_EN.
//
// state    | meaning
// ST_IDLE  | waiting for the sample tick; snapshot inputs on tick
// ST_SUM   | accumulate one voice per cycle
// ST_WAIT  | mixed word ready, waiting for codec FIFO space
// ST_WRITE | write strobe high for this single cycle
module voice_mixer
   import audio_pkg::*;
#(
   parameter int NUM_VOICES  = 4,
   parameter int SAMPLE_W    = 5,
   parameter int OUT_W       = 24,
   parameter int TICK_PERIOD = DEFAULT_TICK_PERIOD
) (
   input  logic                           CLOCK_50,
   input  logic                           reset,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
   input  logic [NUM_VOICES-1:0]          voice_active,
   input  logic                           audio_out_allowed,
   output logic                           write_audio_out,
   output logic [OUT_W-1:0]               left_channel_audio_out,
   output logic [OUT_W-1:0]               right_channel_audio_out,
   output logic                           busy
`ifdef VOICE_MIXER_OVERRUN_EN
   ,
   output logic [15:0]                    overrun_count
`endif
);

   localparam int ACC_W = acc_w(SAMPLE_W, NUM_VOICES);
   localparam int MID   = sample_mid(SAMPLE_W);
   localparam int IDX_W = $clog2(NUM_VOICES);

   logic                           tick;
   mix_state_t                     state;
   logic [IDX_W-1:0]               idx;
   logic [NUM_VOICES*SAMPLE_W-1:0] snap_sample;
   logic [NUM_VOICES-1:0]          snap_active;
   logic signed [ACC_W-1:0]        acc;
   logic [SAMPLE_W-1:0]            voice_arr [NUM_VOICES];
   logic signed [ACC_W-1:0]        cur_term;
   logic [OUT_W-1:0]               mix_word;

   sample_tick_gen #(.TICK_PERIOD(TICK_PERIOD)) u_tick (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .tick     (tick)
   );

   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++)
         voice_arr[i] = snap_sample[i*SAMPLE_W +: SAMPLE_W];
   end

   // Inactive voices contribute silence, i.e. the midpoint, i.e. zero.
   always_comb begin
      cur_term = '0;
      if (snap_active[idx])
         cur_term = ACC_W'(signed'({1'b0, voice_arr[idx]})) - ACC_W'(MID);
   end

   assign mix_word = {acc, {(OUT_W-ACC_W){1'b0}}};

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state                   <= ST_IDLE;
         idx                     <= '0;
         snap_sample             <= '0;
         snap_active             <= '0;
         acc                     <= '0;
         write_audio_out         <= 1'b0;
         left_channel_audio_out  <= '0;
         right_channel_audio_out <= '0;
         busy                    <= 1'b0;
      end else begin
         write_audio_out <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tick) begin
                  snap_sample <= voice_sample;
                  snap_active <= voice_active;
                  acc         <= '0;
                  idx         <= '0;
                  busy        <= 1'b1;
                  state       <= ST_SUM;
               end
            end
            ST_SUM: begin
               acc <= acc + cur_term;
               idx <= idx + 1'b1;
               if (idx == IDX_W'(NUM_VOICES - 1))
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (audio_out_allowed) begin
                  write_audio_out         <= 1'b1;
                  left_channel_audio_out  <= mix_word;
                  right_channel_audio_out <= mix_word;
                  state                   <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef VOICE_MIXER_OVERRUN_EN
   // A tick that finds the FSM busy is dropped; count it, saturating.
   always_ff @(posedge CLOCK_50) begin
      if (reset)
         overrun_count <= '0;
      else if (tick && (state != ST_IDLE) && (overrun_count != 16'hFFFF))
         overrun_count <= overrun_count + 16'd1;
   end
`endif

endmodule
